// File: rtl/noise_acq_pkg.sv
// noise_acq_pkg: shared widths and the ADC sample-format helper for noise_acq_core.
// Build option: define NOISE_ACQ_SIGN_EXT_EN to store samples as sign-extended
// two's complement. Leave it undefined to store zero-extended offset binary.
`timescale 1ns/1ps
package noise_acq_pkg;
   localparam int ADC_W     = 12;
   localparam int ACQ_W     = 12;
   localparam int DIV_W     = 10;
   localparam int DATA_W    = 16;
   localparam int RAM_DEPTH = 4096;
   localparam int ADDR_W    = 12;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] word_t;

   // Offset binary to stored word. Flipping the MSB makes the sample two's
   // complement, and the flipped MSB is then sign-extended.
   function automatic word_t fmt_sample(input logic [ADC_W-1:0] adc);
`ifdef NOISE_ACQ_SIGN_EXT_EN
      return {{(DATA_W-ADC_W+1){~adc[ADC_W-1]}}, adc[ADC_W-2:0]};
`else
      return {{(DATA_W-ADC_W){1'b0}}, adc};
`endif
   endfunction
endpackage

// File: rtl/noise_acq_if.sv
// noise_acq_if: control, ADC and DSP readback signals of the noise acquisition core.
`timescale 1ns/1ps
interface noise_acq_if;
   import noise_acq_pkg::*;

   logic              noise_load;
   logic [ACQ_W-1:0]  n_acqnum;
   logic [DIV_W-1:0]  n_divnum;
   logic [ADC_W-1:0]  n_ADC;
   logic              RAM_WT_EN;
   logic              RAM_RDaddr_rst;
   logic              RAM_RD_EN;
   logic              XRD;
   logic [DATA_W-1:0] RAM_data;
   logic              Noise_acq_clk;

   modport master (
      output noise_load, n_acqnum, n_divnum, n_ADC, RAM_WT_EN,
             RAM_RDaddr_rst, RAM_RD_EN, XRD,
      input  RAM_data, Noise_acq_clk
   );

   modport slave (
      input  noise_load, n_acqnum, n_divnum, n_ADC, RAM_WT_EN,
             RAM_RDaddr_rst, RAM_RD_EN, XRD,
      output RAM_data, Noise_acq_clk
   );
endinterface

// File: rtl/noise_acq_clkdiv.sv
// noise_acq_clkdiv: divides clk by 2*divnum into a registered ADC sampling clock.
// It also gives a strobe that is high during the cycle whose edge takes the
// clock from 1 to 0.
`timescale 1ns/1ps
module noise_acq_clkdiv
   import noise_acq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] divnum,
   output logic             acq_clk,
   output logic             fall_stb
);
   logic [DIV_W-1:0] cnt;
   logic             run;
   logic             wrap;

   // A divide value of 0 parks the clock low. Load also holds it in reset.
   assign run      = !load && (divnum != '0);
   assign wrap     = run && (cnt == divnum - DIV_W'(1));
   assign fall_stb = wrap && acq_clk;

   // Half-period counter. The sampling clock toggles on every wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         acq_clk <= 1'b0;
      end else if (load) begin
         cnt     <= '0;
         acq_clk <= 1'b0;
      end else if (run) begin
         if (wrap) begin
            cnt     <= '0;
            acq_clk <= ~acq_clk;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end
endmodule

// File: rtl/noise_acq_core.sv
// noise_acq_core: acquires a programmed number of ADC noise samples into a 4096x16 RAM.
// The DSP reads the samples back one word per XRD strobe.
// Build option: NOISE_ACQ_SIGN_EXT_EN selects the stored sample format
// (see noise_acq_pkg::fmt_sample).
`timescale 1ns/1ps
module noise_acq_core
   import noise_acq_pkg::*;
(
   input  logic        clk_sys,
   input  logic        n_reset,
   noise_acq_if.slave  bus
);
   logic [ACQ_W-1:0] acq_q;
   logic [DIV_W-1:0] div_q;
   addr_t            wr_addr;
   logic [ACQ_W-1:0] wr_cnt;
   logic             done;
   logic             acq_clk;
   logic             fall_stb;
   logic             we;

   word_t            ram [RAM_DEPTH];

   logic             xrd_m, xrd_s, xrd_d;
   logic             rd_rise;
   addr_t            rd_addr;
   word_t            rd_data;

   noise_acq_clkdiv u_clkdiv (
      .clk      (clk_sys),
      .rst      (n_reset),
      .load     (bus.noise_load),
      .divnum   (div_q),
      .acq_clk  (acq_clk),
      .fall_stb (fall_stb)
   );

   assign bus.Noise_acq_clk = acq_clk;
   assign bus.RAM_data      = rd_data;

   // The sample is taken on the falling toggle, mid-period for an ADC that updates on the rise.
   // The count compare also blocks a write in the cycle before done registers.
   assign we = fall_stb && bus.RAM_WT_EN && !done && (wr_cnt != acq_q);

   // Latch the parameters while load is high; then track the write address and sample count.
   always_ff @(posedge clk_sys or posedge n_reset) begin
      if (n_reset) begin
         acq_q   <= '0;
         div_q   <= '0;
         wr_addr <= '0;
         wr_cnt  <= '0;
         done    <= 1'b0;
      end else if (bus.noise_load) begin
         acq_q   <= bus.n_acqnum;
         div_q   <= bus.n_divnum;
         wr_addr <= '0;
         wr_cnt  <= '0;
         done    <= 1'b0;
      end else begin
         if (we) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            wr_cnt  <= wr_cnt + ACQ_W'(1);
         end
         if (wr_cnt == acq_q)
            done <= 1'b1;
      end
   end

   // Sample RAM write port. It has no reset, so the contents survive reset and load.
   always_ff @(posedge clk_sys) begin
      if (we)
         ram[wr_addr] <= fmt_sample(bus.n_ADC);
   end

   // XRD is idle high, so the synchronizer resets high. This avoids a false rise after reset.
   assign rd_rise = xrd_s && !xrd_d;

   // Synchronize XRD and step the read address on each completed read.
   // Drive the registered read port.
   always_ff @(posedge clk_sys or posedge n_reset) begin
      if (n_reset) begin
         xrd_m   <= 1'b1;
         xrd_s   <= 1'b1;
         xrd_d   <= 1'b1;
         rd_addr <= '0;
         rd_data <= '0;
      end else begin
         xrd_m <= bus.XRD;
         xrd_s <= xrd_m;
         xrd_d <= xrd_s;
         if (bus.RAM_RDaddr_rst)
            rd_addr <= '0;
         else if (bus.RAM_RD_EN && rd_rise)
            rd_addr <= rd_addr + ADDR_W'(1);
         rd_data <= bus.RAM_RD_EN ? ram[rd_addr] : '0;
      end
   end
endmodule

// File: tb/tb_noise_acq_core.sv
// tb_noise_acq_core: directed test of noise_acq_core covering reset, the divider,
// acquisition, readback, edge values, restart and the read controls.
`timescale 1ns/1ps
module tb_noise_acq_core;
   import noise_acq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   noise_acq_if bus();

   noise_acq_core dut (
      .clk_sys (clk),
      .n_reset (rst),
      .bus     (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] mmem [0:4095];
   int          mcnt = 0;
   int          macq = 0;

   // Expected stored word, computed arithmetically (sample value minus mid-scale).
   function automatic logic [15:0] exp_word(input logic [11:0] a);
`ifdef NOISE_ACQ_SIGN_EXT_EN
      int v;
      v = int'(a) - 2048;
      return v[15:0];
`else
      return {4'h0, a};
`endif
   endfunction

   // The ADC presents a new random sample on each sampling-clock rise.
   initial begin
      bus.n_ADC = '0;
      forever begin
         @(posedge bus.Noise_acq_clk);
         bus.n_ADC = 12'($urandom);
      end
   end

   // Expected RAM image: one sample per falling sampling clock while enabled and not full.
   initial begin
      for (int i = 0; i < 4096; i++) mmem[i] = '0;
      forever begin
         @(negedge bus.Noise_acq_clk);
         if (!rst && !bus.noise_load && bus.RAM_WT_EN && mcnt < macq) begin
            mmem[mcnt] = exp_word(bus.n_ADC);
            mcnt++;
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [11:0] acq, input logic [9:0] div);
      bus.n_acqnum   = acq;
      bus.n_divnum   = div;
      bus.noise_load = 1'b1;
      mcnt = 0;
      macq = int'(acq);
      cycles(2);
      bus.noise_load = 1'b0;
   endtask

   task automatic wait_lvl(input logic lvl, input int max, output int cyc);
      cyc = 0;
      while (bus.Noise_acq_clk !== lvl && cyc <= max) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_cnt(input int target, input int max, output bit ok);
      int c = 0;
      while (mcnt < target && c < max) begin
         @(negedge clk);
         c++;
      end
      ok = (mcnt == target);
   endtask

   task automatic rd_start();
      bus.RAM_RD_EN      = 1'b1;
      bus.RAM_RDaddr_rst = 1'b1;
      cycles(2);
      bus.RAM_RDaddr_rst = 1'b0;
      cycles(2);
   endtask

   task automatic xrd_pulse(input int half);
      bus.XRD = 1'b0;
      cycles(half);
      bus.XRD = 1'b1;
      cycles(half);
   endtask

   task automatic test_reset();
      bit bad = 0;
      bus.noise_load = 0; bus.n_acqnum = '0; bus.n_divnum = '0;
      bus.RAM_WT_EN = 0; bus.RAM_RDaddr_rst = 0; bus.RAM_RD_EN = 1; bus.XRD = 1;
      rst = 1'b1;
      cycles(3);
      n_checks++;
      if (bus.Noise_acq_clk !== 1'b0) begin
         n_fail++; $display("FAIL reset_clk: got %b expected 0", bus.Noise_acq_clk);
      end
      n_checks++;
      if (bus.RAM_data !== 16'h0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0000", bus.RAM_data);
      end
      bus.RAM_RD_EN = 0;
      rst = 1'b0;
      bus.RAM_WT_EN = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.Noise_acq_clk !== 1'b0) bad = 1;
      end
      n_checks++;
      if (bad) begin
         n_fail++; $display("FAIL post_reset_idle: got clock activity expected none");
      end
   endtask

   task automatic test_div330();
      int c; time t0;
      bus.RAM_WT_EN = 0;
      do_load(12'd0, 10'd330);
      wait_lvl(1'b1, 400, c);
      n_checks++;
      if (c != 330) begin
         n_fail++; $display("FAIL first_rise_330: got %0d cycles expected 330", c);
      end
      t0 = $time;
      wait_lvl(1'b0, 400, c);
      n_checks++;
      if (c != 330) begin
         n_fail++; $display("FAIL high_phase_330: got %0d cycles expected 330", c);
      end
      wait_lvl(1'b1, 400, c);
      n_checks++;
      if ($time - t0 != 6600) begin
         n_fail++; $display("FAIL period_330: got %0t expected 6600 ns", $time - t0);
      end
   endtask

   task automatic test_div1_prefill();
      int c; time t0; bit ok;
      bus.RAM_WT_EN = 1;
      do_load(12'd310, 10'd1);
      wait_lvl(1'b1, 10, c);
      n_checks++;
      if (c != 1) begin
         n_fail++; $display("FAIL first_rise_1: got %0d cycles expected 1", c);
      end
      t0 = $time;
      wait_lvl(1'b0, 10, c);
      wait_lvl(1'b1, 10, c);
      n_checks++;
      if ($time - t0 != 20) begin
         n_fail++; $display("FAIL period_1: got %0t expected 20 ns", $time - t0);
      end
      wait_cnt(310, 2000, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL prefill_done: got %0d samples expected 310", mcnt);
      end
      cycles(10);
   endtask

   task automatic test_acquisition();
      bit ok;
      bus.RAM_WT_EN = 1;
      do_load(12'd300, 10'd3);
      wait_cnt(300, 3000, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL acq_done: got %0d samples expected 300", mcnt);
      end
      cycles(40);
      rd_start();
      for (int i = 0; i <= 300; i++) begin
         if (i > 0) xrd_pulse(5);
         n_checks++;
         if (bus.RAM_data !== mmem[i]) begin
            n_fail++; $display("FAIL acq_read[%0d]: got %h expected %h", i, bus.RAM_data, mmem[i]);
         end
      end
      bus.RAM_RD_EN = 0;
   endtask

   task automatic test_edge_values();
      bit bad = 0;
      bus.RAM_WT_EN = 1;
      do_load(12'd5, 10'd0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.Noise_acq_clk !== 1'b0) bad = 1;
      end
      n_checks++;
      if (bad) begin
         n_fail++; $display("FAIL div0_stuck: got clock activity expected stuck low");
      end
      do_load(12'd0, 10'd1);
      cycles(50);
      rd_start();
      n_checks++;
      if (bus.RAM_data !== mmem[0]) begin
         n_fail++; $display("FAIL acq0_addr0: got %h expected %h", bus.RAM_data, mmem[0]);
      end
      xrd_pulse(5);
      n_checks++;
      if (bus.RAM_data !== mmem[1]) begin
         n_fail++; $display("FAIL acq0_addr1: got %h expected %h", bus.RAM_data, mmem[1]);
      end
      bus.RAM_RD_EN = 0;
   endtask

   task automatic test_restart();
      bit ok;
      bus.RAM_WT_EN = 1;
      do_load(12'd100, 10'd2);
      wait_cnt(50, 1000, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL restart_first50: got %0d samples expected 50", mcnt);
      end
      bus.n_acqnum   = 12'd10;
      bus.noise_load = 1'b1;
      macq = 10;
      mcnt = 0;
      cycles(3);
      n_checks++;
      if (bus.Noise_acq_clk !== 1'b0) begin
         n_fail++; $display("FAIL load_holds_clk: got %b expected 0", bus.Noise_acq_clk);
      end
      bus.noise_load = 1'b0;
      wait_cnt(10, 500, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL restart_done: got %0d samples expected 10", mcnt);
      end
      cycles(60);
      rd_start();
      for (int i = 0; i < 60; i++) begin
         if (i > 0) xrd_pulse(5);
         n_checks++;
         if (bus.RAM_data !== mmem[i]) begin
            n_fail++; $display("FAIL restart_read[%0d]: got %h expected %h", i, bus.RAM_data, mmem[i]);
         end
      end
      bus.RAM_RD_EN = 0;
   endtask

   task automatic test_read_controls();
      rd_start();
      xrd_pulse(5);
      n_checks++;
      if (bus.RAM_data !== mmem[1]) begin
         n_fail++; $display("FAIL rc_addr1: got %h expected %h", bus.RAM_data, mmem[1]);
      end
      bus.RAM_RD_EN = 0;
      cycles(2);
      n_checks++;
      if (bus.RAM_data !== 16'h0) begin
         n_fail++; $display("FAIL rden0_data: got %h expected 0000", bus.RAM_data);
      end
      xrd_pulse(5);
      xrd_pulse(5);
      n_checks++;
      if (bus.RAM_data !== 16'h0) begin
         n_fail++; $display("FAIL rden0_after_xrd: got %h expected 0000", bus.RAM_data);
      end
      bus.RAM_RD_EN = 1;
      cycles(2);
      n_checks++;
      if (bus.RAM_data !== mmem[1]) begin
         n_fail++; $display("FAIL rden0_no_advance: got %h expected %h", bus.RAM_data, mmem[1]);
      end
      xrd_pulse(5);
      xrd_pulse(5);
      n_checks++;
      if (bus.RAM_data !== mmem[3]) begin
         n_fail++; $display("FAIL rc_addr3: got %h expected %h", bus.RAM_data, mmem[3]);
      end
      // Address reset held only for the cycle in which the synchronized rise lands.
      bus.XRD = 1'b0;
      cycles(5);
      bus.XRD = 1'b1;
      cycles(2);
      bus.RAM_RDaddr_rst = 1'b1;
      cycles(1);
      bus.RAM_RDaddr_rst = 1'b0;
      cycles(4);
      n_checks++;
      if (bus.RAM_data !== mmem[0]) begin
         n_fail++; $display("FAIL rst_priority: got %h expected %h", bus.RAM_data, mmem[0]);
      end
      for (int i = 0; i < 4096; i++) xrd_pulse(4);
      n_checks++;
      if (bus.RAM_data !== mmem[0]) begin
         n_fail++; $display("FAIL wrap_4096: got %h expected %h", bus.RAM_data, mmem[0]);
      end
      xrd_pulse(4);
      n_checks++;
      if (bus.RAM_data !== mmem[1]) begin
         n_fail++; $display("FAIL wrap_4097: got %h expected %h", bus.RAM_data, mmem[1]);
      end
      bus.RAM_RD_EN = 0;
   endtask

   initial begin
      test_reset();
      test_div330();
      test_div1_prefill();
      test_acquisition();
      test_edge_values();
      test_restart();
      test_read_controls();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/noise_acq_core.md
# noise_acq_core

Noise-acquisition block for the NMR front end. It divides `clk_sys` into a programmable ADC sampling clock and stores a programmed number of 12-bit ADC noise samples into an internal 4096×16 RAM. The DSP then reads the RAM back word by word using its `XRD` read strobe. It sits between the ADC interface and the DSP external-bus readback path.

## Interface
- No parameters; widths come from the package.
- `clk_sys` in 1 — system clock; all logic is on its rising edge.
- `n_reset` in 1 — asynchronous, active-high reset.
- `noise_load` in 1 — level; while high, latches `n_acqnum`/`n_divnum` and clears all acquisition state.
- `n_acqnum` in 12 — number of samples to acquire (0..4095).
- `n_divnum` in 10 — half-period of `Noise_acq_clk`, in `clk_sys` cycles.
- `n_ADC` in 12 — ADC sample, offset binary.
- `RAM_WT_EN` in 1 — acquisition/write enable.
- `RAM_RDaddr_rst` in 1 — level; while high, read address = 0.
- `RAM_RD_EN` in 1 — readback enable.
- `XRD` in 1 — DSP read strobe, active low, asynchronous to `clk_sys`.
- `RAM_data` out 16 — readback word.
- `Noise_acq_clk` out 1 — ADC sampling clock (registered).

## Operation
- **Reset values:** `Noise_acq_clk`=0, `RAM_data`=0. Internal counters, addresses, latched parameters and the done flag are 0. RAM contents are not reset.
- **Load:** while `noise_load`=1, the block:
  - latches `n_acqnum` and `n_divnum`;
  - sets write address, sample count and divider count to 0;
  - holds `Noise_acq_clk`=0 and clears done.
- Asserting load mid-acquisition restarts the acquisition.
- **Divider:** runs whenever load is low and latched `n_divnum`≠0.
  - Counts 0..n_divnum−1.
  - Toggles `Noise_acq_clk` when the count reaches n_divnum−1, then wraps to 0.
  - Period = 2·n_divnum cycles.
  - With `n_divnum`=0, the clock is held low and no samples are taken.
- **Write:** on each cycle in which `Noise_acq_clk` toggles 1→0, with `RAM_WT_EN`=1 and not done:
  - RAM[wr_addr] ← formatted `n_ADC`;
  - wr_addr and count increment.
- When count reaches latched `n_acqnum`, done is set and further writes stop.
- `n_acqnum`=0 means nothing is written.
- `RAM_WT_EN` low suppresses writes; the divider keeps running.
- **Read:**
  - `XRD` passes through a 2-flop synchronizer; a synchronized rising edge is a read-complete event.
  - When `RAM_RD_EN`=1, each read-complete event increments rd_addr. It wraps 4095→0.
  - `RAM_RDaddr_rst` has priority over an increment in the same cycle.
  - `RAM_data` is registered: RAM[rd_addr] when `RAM_RD_EN`=1, otherwise 0.
- Simultaneous write and read of the same address returns the old data.

## Timing
- `Noise_acq_clk` first rises n_divnum cycles after `noise_load` falls (load low, `n_divnum`≥1).
- A sample is captured at the falling toggle, mid-period relative to an ADC updated on the rising edge.
- The RAM write lands in the same `clk_sys` edge as the falling toggle.
- Read latency:
  - `XRD` rise → rd_addr increment: 3 cycles (2 sync, 1 edge detect/update).
  - rd_addr change → `RAM_data` valid: 1 further cycle.
- `XRD` high/low phases must each be ≥3 `clk_sys` cycles.

## Configuration
- Macro `NOISE_ACQ_SIGN_EXT_EN`:
  - **Defined:** stored word = {4{~n_ADC[11]}, ~n_ADC[11], n_ADC[10:0]}, i.e. offset binary converted to two's complement and sign-extended to 16 bits.
  - **Undefined:** stored word = {4'b0, n_ADC} (zero-extended).

## Structure
- Package `noise_acq_pkg` holds:
  - width constants: ADC 12, acqnum 12, divnum 10, data 16, RAM depth 4096, address 12;
  - the sample-format function.
- One sub-module, `noise_acq_clkdiv`, implements the divider and emits `Noise_acq_clk` plus a one-cycle fall-toggle strobe.
- RAM is an inferred array in the top.

## Test plan
- **Reset:** hold `n_reset`=1 → `Noise_acq_clk`=0, `RAM_data`=0; after release, no writes occur.
- **Acquisition:** load n_acqnum=300, n_divnum=330, `RAM_WT_EN`=1, with `n_ADC` random on each `Noise_acq_clk` rise →
  - `Noise_acq_clk` period is 6600 ns;
  - exactly 300 words are written at addresses 0..299;
  - address 300 is untouched.
- **Readback:** pulse `RAM_RDaddr_rst`, set `RAM_RD_EN`=1, toggle `XRD` with a 100 ns period → `RAM_data` sequence matches the captured samples in order, formatted per the macro.
- **Edge values:** n_divnum=1 → period 2 cycles. n_divnum=0 → clock stuck low. n_acqnum=0 → no writes.
- **Restart:** re-assert `noise_load` after 50 samples with n_acqnum=10 → writes restart at address 0 and stop after 10 samples.
- **Read controls:**
  - `RAM_RD_EN`=0 → `RAM_data`=0 and `XRD` edges do not advance the address;
  - `RAM_RDaddr_rst` coincident with an `XRD` rise → address 0;
  - 4096 reads → address wraps to 0.
